// File: rtl/fruit_game_ctrl_if.sv
// ----------------------------------------------------------------------------
// fruit_game_ctrl_if
// Bundles the game controller's frame, cursor, fruit-slot and status signals.
//   master : environment side (video timing, mouse, fruit physics, display)
//            drives frame_tick, start_btn, mouse_*, fruit_* and observes the
//            controller outputs.
//   slave  : controller side; receives the inputs above and drives
//            move_fruit, remove_fruit, spawn_req, start_bg, gg_bg, score,
//            lives and game_over.
// Parameters: NUM_FRUITS slots, COORD_W coordinate width, SCORE_W score width.
// ----------------------------------------------------------------------------
interface fruit_game_ctrl_if #(
   parameter int NUM_FRUITS = 4,
   parameter int COORD_W    = 10,
   parameter int SCORE_W    = 8
);
   logic                          frame_tick;
   logic                          start_btn;
   logic [COORD_W-1:0]            mouse_x;
   logic [COORD_W-1:0]            mouse_y;
   logic                          mouse_click;
   logic [NUM_FRUITS*COORD_W-1:0] fruit_x;
   logic [NUM_FRUITS*COORD_W-1:0] fruit_y;
   logic [NUM_FRUITS-1:0]         fruit_active;
   logic [NUM_FRUITS-1:0]         fruit_bomb;

   logic                          move_fruit;
   logic [NUM_FRUITS-1:0]         remove_fruit;
   logic [NUM_FRUITS-1:0]         spawn_req;
   logic                          start_bg;
   logic                          gg_bg;
   logic [SCORE_W-1:0]            score;
   logic [2:0]                    lives;
   logic                          game_over;

   modport master (
      output frame_tick, start_btn, mouse_x, mouse_y, mouse_click,
             fruit_x, fruit_y, fruit_active, fruit_bomb,
      input  move_fruit, remove_fruit, spawn_req, start_bg, gg_bg,
             score, lives, game_over
   );

   modport slave (
      input  frame_tick, start_btn, mouse_x, mouse_y, mouse_click,
             fruit_x, fruit_y, fruit_active, fruit_bomb,
      output move_fruit, remove_fruit, spawn_req, start_bg, gg_bg,
             score, lives, game_over
   );
endinterface

// File: rtl/fruit_game_ctrl.sv
// ----------------------------------------------------------------------------
// fruit_game_ctrl
// Game-flow controller for a fruit-cutting game. Between frames it lets the
// physics run (PLAY); on each frame tick it walks the fruit slots one per
// cycle (SCAN) scoring cursor hits and charging lives for fruit that fell to
// the floor, then requests at most one new fruit (SPAWN). Running out of
// lives ends the game (GAME_OVER).
// Ports:
//   clk   : system clock, all state on posedge
//   reset : synchronous, active-low
//   bus   : fruit_game_ctrl_if.slave (frame/cursor/fruit inputs, status outs)
// Build option: define BOMB_EN to honour fruit_bomb (a cut bomb empties the
// lives counter, a bomb hitting the floor costs nothing). Without it
// fruit_bomb is ignored and bombs behave as ordinary fruit.
// ----------------------------------------------------------------------------
module fruit_game_ctrl #(
   parameter int NUM_FRUITS  = 4,
   parameter int COORD_W     = 10,
   parameter int HIT_R       = 16,
   parameter int FLOOR_Y     = 479,
   parameter int START_LIVES = 3,
   parameter int SCORE_W     = 8
) (
   input logic              clk,
   input logic              reset,
   fruit_game_ctrl_if.slave bus
);

   localparam int                 IDX_W         = (NUM_FRUITS > 1) ? $clog2(NUM_FRUITS) : 1;
   localparam logic [COORD_W-1:0] HIT_R_C       = COORD_W'(HIT_R);
   localparam logic [COORD_W-1:0] FLOOR_Y_C     = COORD_W'(FLOOR_Y);
   localparam logic [2:0]         START_LIVES_C = 3'(START_LIVES);
   localparam logic [IDX_W-1:0]   LAST_IDX      = IDX_W'(NUM_FRUITS - 1);

   typedef enum logic [2:0] {IDLE, PLAY, SCAN, SPAWN, GAME_OVER} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [SCORE_W-1:0]    score_q, score_d;
   logic [2:0]            lives_q, lives_d;
   logic                  click_pend_q, click_pend_d;
   logic                  click_hold_q, click_hold_d;
   logic                  start_prev_q, click_prev_q;
   logic [NUM_FRUITS-1:0] removed_q, removed_d;
   logic [NUM_FRUITS-1:0] remove_q, remove_d;
   logic [NUM_FRUITS-1:0] spawn_q, spawn_d;
   logic                  move_q, move_d;
   logic                  start_bg_q, start_bg_d;
   logic                  over_q, over_d;

   logic                  start_rise, click_rise;
   logic [COORD_W-1:0]    cur_x, cur_y;
   logic                  cur_active, cur_bomb, cur_hit, cur_miss;
   logic [NUM_FRUITS-1:0] spawn_pick;

   // Unsigned distance without wrap-around.
   function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   assign start_rise = bus.start_btn & ~start_prev_q;
   assign click_rise = bus.mouse_click & ~click_prev_q;

   assign cur_x      = bus.fruit_x[int'(idx_q)*COORD_W +: COORD_W];
   assign cur_y      = bus.fruit_y[int'(idx_q)*COORD_W +: COORD_W];
   assign cur_active = bus.fruit_active[idx_q];

`ifdef BOMB_EN
   assign cur_bomb = bus.fruit_bomb[idx_q];
`else
   logic unused_bomb;
   assign unused_bomb = ^bus.fruit_bomb;
   assign cur_bomb    = 1'b0;
`endif

   assign cur_hit  = cur_active & click_pend_q
                   & (abs_diff(bus.mouse_x, cur_x) <= HIT_R_C)
                   & (abs_diff(bus.mouse_y, cur_y) <= HIT_R_C);
   // A hit on the same slot wins over a floor miss.
   assign cur_miss = cur_active & ~cur_hit & (cur_y >= FLOOR_Y_C);

   // Lowest slot that is free now or was cleared during this frame's scan.
   always_comb begin
      logic found;
      spawn_pick = '0;
      found      = 1'b0;
      for (int i = 0; i < NUM_FRUITS; i++) begin
         if (!found && (!bus.fruit_active[i] || removed_q[i])) begin
            spawn_pick[i] = 1'b1;
            found         = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      score_d      = score_q;
      lives_d      = lives_q;
      click_pend_d = click_pend_q;
      click_hold_d = click_hold_q;
      removed_d    = removed_q;
      remove_d     = '0;
      spawn_d      = '0;

      case (state_q)
         IDLE: begin
            if (start_rise) begin
               state_d      = PLAY;
               score_d      = '0;
               lives_d      = START_LIVES_C;
               click_pend_d = 1'b0;
               click_hold_d = 1'b0;
            end
         end

         PLAY: begin
            click_pend_d = click_pend_q | click_rise;
            if (bus.frame_tick) begin
               state_d   = SCAN;
               idx_d     = '0;
               removed_d = '0;
            end
         end

         SCAN: begin
            // Clicks arriving mid-scan belong to the next frame.
            click_hold_d = click_hold_q | click_rise;
            if (cur_hit) begin
               remove_d[idx_q]  = 1'b1;
               removed_d[idx_q] = 1'b1;
               if (cur_bomb)
                  lives_d = '0;
               else if (score_q != '1)
                  score_d = score_q + 1'b1;
            end else if (cur_miss) begin
               remove_d[idx_q]  = 1'b1;
               removed_d[idx_q] = 1'b1;
               if (!cur_bomb && lives_q != 3'd0)
                  lives_d = lives_q - 3'd1;
            end
            if (idx_q == LAST_IDX) begin
               state_d      = SPAWN;
               click_pend_d = 1'b0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         SPAWN: begin
            if (lives_q == 3'd0) begin
               state_d      = GAME_OVER;
               click_hold_d = 1'b0;
            end else begin
               state_d      = PLAY;
               spawn_d      = spawn_pick;
               click_pend_d = click_hold_q | click_rise;
               click_hold_d = 1'b0;
            end
         end

         GAME_OVER: begin
            click_pend_d = 1'b0;
            click_hold_d = 1'b0;
            if (start_rise)
               state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // Status outputs are registered from the next state.
      move_d     = (state_d == PLAY);
      start_bg_d = (state_d == IDLE);
      over_d     = (state_d == GAME_OVER);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         score_q      <= '0;
         lives_q      <= START_LIVES_C;
         click_pend_q <= 1'b0;
         click_hold_q <= 1'b0;
         start_prev_q <= 1'b0;
         click_prev_q <= 1'b0;
         removed_q    <= '0;
         remove_q     <= '0;
         spawn_q      <= '0;
         move_q       <= 1'b0;
         start_bg_q   <= 1'b1;
         over_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
         click_pend_q <= click_pend_d;
         click_hold_q <= click_hold_d;
         start_prev_q <= bus.start_btn;
         click_prev_q <= bus.mouse_click;
         removed_q    <= removed_d;
         remove_q     <= remove_d;
         spawn_q      <= spawn_d;
         move_q       <= move_d;
         start_bg_q   <= start_bg_d;
         over_q       <= over_d;
      end
   end

   assign bus.move_fruit   = move_q;
   assign bus.remove_fruit = remove_q;
   assign bus.spawn_req    = spawn_q;
   assign bus.start_bg     = start_bg_q;
   assign bus.gg_bg        = over_q;
   assign bus.game_over    = over_q;
   assign bus.score        = score_q;
   assign bus.lives        = lives_q;

endmodule

// File: tb/tb_fruit_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fruit_game_ctrl
// Bench for fruit_game_ctrl. A frame-level reference model predicts every
// output each cycle; directed scenarios add literal expectations, followed
// by a randomized run. Define BOMB_EN for both DUT and bench to cover the
// bomb build.
// ----------------------------------------------------------------------------
module tb_fruit_game_ctrl;
   localparam int N     = 4;
   localparam int CW    = 10;
   localparam int SW    = 8;
   localparam int HIT   = 16;
   localparam int FLOOR = 479;
   localparam int START = 3;
   localparam int SMAX  = (1 << SW) - 1;

   localparam int M_IDLE = 0;
   localparam int M_PLAY = 1;
   localparam int M_BUSY = 2;
   localparam int M_OVER = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fruit_game_ctrl_if #(.NUM_FRUITS(N), .COORD_W(CW), .SCORE_W(SW)) bus ();

   fruit_game_ctrl #(
      .NUM_FRUITS(N), .COORD_W(CW), .HIT_R(HIT), .FLOOR_Y(FLOOR),
      .START_LIVES(START), .SCORE_W(SW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   int m_mode = M_IDLE, m_cnt = 0, m_score = 0, m_lives = START;
   bit m_pend = 1'b0, m_prev_start = 1'b0, m_prev_click = 1'b0;
   int f_rem [N];
   int f_sc  [N+1];
   int f_lv  [N+1];
   int f_spawn = 0;
   int e_remove = 0, e_spawn = 0;

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   // Whole-frame outcome from the inputs seen at the frame tick.
   task automatic plan_frame(input bit clk_pend);
      int sc, lv, fx, fy, mx, my;
      bit act, bomb, hit, miss;
      sc = m_score;
      lv = m_lives;
      mx = int'(bus.mouse_x);
      my = int'(bus.mouse_y);
      f_sc[0] = sc;
      f_lv[0] = lv;
      for (int i = 0; i < N; i++) begin
         fx   = int'(bus.fruit_x[i*CW +: CW]);
         fy   = int'(bus.fruit_y[i*CW +: CW]);
         act  = bus.fruit_active[i];
         bomb = 1'b0;
`ifdef BOMB_EN
         bomb = bus.fruit_bomb[i];
`endif
         hit  = act && clk_pend && absd(mx, fx) <= HIT && absd(my, fy) <= HIT;
         miss = act && !hit && fy >= FLOOR;
         f_rem[i] = (hit || miss) ? 1 : 0;
         if (hit) begin
            if (bomb) lv = 0;
            else      sc = (sc < SMAX) ? sc + 1 : SMAX;
         end else if (miss && !bomb) begin
            lv = (lv > 0) ? lv - 1 : 0;
         end
         f_sc[i+1] = sc;
         f_lv[i+1] = lv;
      end
      f_spawn = 0;
      if (lv > 0)
         for (int i = 0; i < N; i++)
            if (f_spawn == 0 && (!bus.fruit_active[i] || f_rem[i] != 0))
               f_spawn = 1 << i;
   endtask

   always @(posedge clk) begin
      bit sr, cr;
      if (!reset) begin
         m_mode = M_IDLE; m_score = 0; m_lives = START; m_pend = 1'b0;
         m_prev_start = 1'b0; m_prev_click = 1'b0; e_remove = 0; e_spawn = 0;
      end else begin
         sr = bus.start_btn && !m_prev_start;
         cr = bus.mouse_click && !m_prev_click;
         m_prev_start = bus.start_btn;
         m_prev_click = bus.mouse_click;
         e_remove = 0;
         e_spawn  = 0;
         case (m_mode)
            M_IDLE: if (sr) begin
               m_mode = M_PLAY; m_score = 0; m_lives = START; m_pend = 1'b0;
            end
            M_PLAY: begin
               m_pend = m_pend | cr;
               if (bus.frame_tick) begin
                  plan_frame(m_pend);
                  m_pend = 1'b0;
                  m_mode = M_BUSY;
                  m_cnt  = 0;
               end
            end
            M_BUSY: begin
               m_pend = m_pend | cr;
               m_cnt++;
               if (m_cnt <= N) begin
                  e_remove = f_rem[m_cnt-1] << (m_cnt - 1);
                  m_score  = f_sc[m_cnt];
                  m_lives  = f_lv[m_cnt];
               end else if (m_lives == 0) begin
                  m_mode = M_OVER;
                  m_pend = 1'b0;
               end else begin
                  e_spawn = f_spawn;
                  m_mode  = M_PLAY;
               end
            end
            default: if (sr) m_mode = M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("remove_fruit", int'(bus.remove_fruit), e_remove);
         check("spawn_req",    int'(bus.spawn_req),    e_spawn);
         check("score",        int'(bus.score),        m_score);
         check("lives",        int'(bus.lives),        m_lives);
         check("move_fruit",   int'(bus.move_fruit),   int'(m_mode == M_PLAY));
         check("start_bg",     int'(bus.start_bg),     int'(m_mode == M_IDLE));
         check("gg_bg",        int'(bus.gg_bg),        int'(m_mode == M_OVER));
         check("game_over",    int'(bus.game_over),    int'(m_mode == M_OVER));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_slot(input int i, input int x, input int y, input bit act, input bit bomb);
      bus.fruit_x[i*CW +: CW] = CW'(x);
      bus.fruit_y[i*CW +: CW] = CW'(y);
      bus.fruit_active[i]     = act;
      bus.fruit_bomb[i]       = bomb;
   endtask

   task automatic clear_slots();
      for (int i = 0; i < N; i++) set_slot(i, 600, 50, 1'b0, 1'b0);
   endtask

   task automatic press_start();
      bus.start_btn = 1'b1; cyc(1);
      bus.start_btn = 1'b0; cyc(1);
   endtask

   task automatic run_frame(input bit with_click);
      if (with_click) begin
         bus.mouse_click = 1'b1; cyc(1);
         bus.mouse_click = 1'b0;
      end
      bus.frame_tick = 1'b1; cyc(1);
      bus.frame_tick = 1'b0; cyc(N + 3);
   endtask

   task automatic do_reset();
      reset = 1'b0; cyc(2);
      reset = 1'b1; cyc(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, fx [N];
      bus.frame_tick = 1'b0; bus.start_btn = 1'b0; bus.mouse_click = 1'b0;
      bus.mouse_x = '0; bus.mouse_y = '0;
      bus.fruit_x = '0; bus.fruit_y = '0; bus.fruit_active = '0; bus.fruit_bomb = '0;
      clear_slots();
      cyc(1);
      chk_en = 1'b1;
      cyc(1);
      reset = 1'b1;
      cyc(1);

      // Reset state
      check("rst_start_bg", int'(bus.start_bg), 1);
      check("rst_score", int'(bus.score), 0);
      check("rst_lives", int'(bus.lives), 3);
      check("rst_game_over", int'(bus.game_over), 0);

      // Game start
      bus.start_btn = 1'b1; cyc(1);
      check("start_move", int'(bus.move_fruit), 1);
      check("start_bg_off", int'(bus.start_bg), 0);
      check("start_score", int'(bus.score), 0);
      check("start_lives", int'(bus.lives), 3);
      bus.start_btn = 1'b0; cyc(1);

      // Single hit in slot 2, slot 0 free for the spawn
      set_slot(2, 100, 200, 1'b1, 1'b0);
      bus.mouse_x = 10'd110; bus.mouse_y = 10'd190;
      bus.mouse_click = 1'b1; cyc(1);
      bus.mouse_click = 1'b0; bus.frame_tick = 1'b1; cyc(1);
      bus.frame_tick = 1'b0; cyc(3);
      check("hit_remove_t4", int'(bus.remove_fruit), 4);
      check("hit_score", int'(bus.score), 1);
      cyc(2);
      check("hit_spawn_t6", int'(bus.spawn_req), 1);
      cyc(2);

      // Click held over two frames scores once
      bus.mouse_click = 1'b1; cyc(1);
      bus.frame_tick = 1'b1; cyc(1); bus.frame_tick = 1'b0; cyc(N + 3);
      check("held_frame1", int'(bus.score), 2);
      bus.frame_tick = 1'b1; cyc(1); bus.frame_tick = 1'b0; cyc(N + 3);
      check("held_frame2", int'(bus.score), 2);
      bus.mouse_click = 1'b0; cyc(1);

      // Bomb in slot 1
      clear_slots();
      set_slot(1, 100, 200, 1'b1, 1'b1);
      bus.mouse_click = 1'b1; cyc(1);
      bus.mouse_click = 1'b0; bus.frame_tick = 1'b1; cyc(1);
      bus.frame_tick = 1'b0; cyc(2);
      check("bomb_remove", int'(bus.remove_fruit), 2);
      cyc(N + 1);
`ifdef BOMB_EN
      check("bomb_score", int'(bus.score), 2);
      check("bomb_game_over", int'(bus.game_over), 1);
`else
      check("bomb_score", int'(bus.score), 3);
      check("bomb_game_over", int'(bus.game_over), 0);
`endif

      // Score saturation
      do_reset();
      press_start();
      for (int i = 0; i < N; i++) set_slot(i, 100, 200, 1'b1, 1'b0);
      bus.mouse_x = 10'd100; bus.mouse_y = 10'd200;
      repeat (66) run_frame(1'b1);
      check("score_saturated", int'(bus.score), 255);

      // Three floor misses end the game
      do_reset();
      press_start();
      clear_slots();
      set_slot(0, 300, FLOOR, 1'b1, 1'b0);
      bus.mouse_x = 10'd0; bus.mouse_y = 10'd0;
      run_frame(1'b0); check("miss_lives1", int'(bus.lives), 2);
      run_frame(1'b0); check("miss_lives2", int'(bus.lives), 1);
      run_frame(1'b0); check("miss_lives3", int'(bus.lives), 0);
      check("miss_gg_bg", int'(bus.gg_bg), 1);
      check("miss_game_over", int'(bus.game_over), 1);
      check("miss_move_off", int'(bus.move_fruit), 0);
      press_start();
      check("over_to_idle", int'(bus.start_bg), 1);

      // Reset during scan of slot 1
      press_start();
      clear_slots();
      set_slot(1, 100, 200, 1'b1, 1'b0);
      bus.mouse_x = 10'd100; bus.mouse_y = 10'd200;
      bus.mouse_click = 1'b1; cyc(1);
      bus.mouse_click = 1'b0; bus.frame_tick = 1'b1; cyc(1);
      bus.frame_tick = 1'b0; cyc(1);
      reset = 1'b0; cyc(1);
      check("rstscan_remove", int'(bus.remove_fruit), 0);
      check("rstscan_idle", int'(bus.start_bg), 1);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         check("rstscan_no_pulse", int'(bus.remove_fruit | bus.spawn_req), 0);
      end

      // Randomized play
      press_start();
      for (int c = 0; c < 3000; c++) begin
         if (m_mode != M_BUSY) begin
            for (int i = 0; i < N; i++) begin
               fx[i] = int'($urandom_range(80, 160));
               set_slot(i, fx[i],
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(470, 500))
                                                     : int'($urandom_range(180, 240)),
                        $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
            end
            k = int'($urandom_range(0, N - 1));
            bus.mouse_x = CW'(fx[k] + int'($urandom_range(0, 40)) - 20);
            bus.mouse_y = CW'($urandom_range(180, 240));
         end
         bus.mouse_click = ($urandom_range(0, 2) == 0);
         bus.frame_tick  = (m_mode == M_PLAY) ? ($urandom_range(0, 3) == 0)
                                              : ($urandom_range(0, 7) == 0);
         if (m_mode == M_IDLE || m_mode == M_OVER)
            bus.start_btn = ($urandom_range(0, 4) == 0);
         else
            bus.start_btn = ($urandom_range(0, 49) == 0);
         cyc(1);
      end
      bus.frame_tick = 1'b0;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
